// File: rtl/voxguard_pkg.sv
// Constants and types shared by the voice scrambler and the receiver-side descrambler.
package voxguard_pkg;

  localparam logic [15:0] SYNC_WORD    = 16'hA55A;
  localparam int          KEY_SLICE_HI = 27;
  localparam int          KEY_SLICE_LO = 12;

  // Generator fixed-point unity (Q4.28) and power-on seed.
  localparam logic [31:0] ONE      = 32'h1000_0000;
  localparam logic [31:0] KEY_SEED = 32'h01F9_7414;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_HDR2 = 3'd3,
    ST_SYNC = 3'd4,
    ST_RUN  = 3'd5
  } scr_state_e;

endpackage

// File: rtl/stream_out_reg.sv
// One-deep valid/ready output register; accepts a new word whenever empty or drained.
module stream_out_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_is_sync,
  input  logic         i_m_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_is_sync,
  output logic         o_load
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         r_is_sync;

  assign o_load    = !r_valid || i_m_ready;
  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_is_sync = r_is_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_is_sync <= 1'b0;
    end else if (o_load) begin
      r_valid <= i_push;
      if (i_push) begin
        r_data    <= i_data;
        r_is_sync <= i_is_sync;
      end
    end
  end

endmodule

// File: rtl/voice_stream_scrambler.sv
// XOR-scrambles PCM samples with the chaotic key stream and periodically emits a
// plaintext sync header so a receiver can re-lock its generator.
//   state | meaning
//   IDLE  | stream disabled, waiting for enable
//   HDR0  | capture key state, emit SYNC_WORD
//   HDR1  | emit key state upper half
//   HDR2  | emit key state lower half
//   SYNC  | one-cycle generator resync strobe
//   RUN   | encrypt accepted samples
module voice_stream_scrambler #(
  parameter int          SAMPLE_WIDTH  = 16,
  parameter int          KEY_WIDTH     = 32,
  parameter int          RESYNC_PERIOD = 1024,
  parameter logic [15:0] SYNC_WORD     = voxguard_pkg::SYNC_WORD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SAMPLE_WIDTH-1:0] s_data,
  input  logic [KEY_WIDTH-1:0]    key_in,
  output logic                    next_key_en,
  output logic                    sync_en,
  output logic [KEY_WIDTH-1:0]    sync_state_out,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [SAMPLE_WIDTH-1:0] m_data,
  output logic                    m_is_sync
);

  import voxguard_pkg::*;

  localparam int             CNT_W    = (RESYNC_PERIOD > 1) ? $clog2(RESYNC_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESYNC_PERIOD - 1);

  scr_state_e               r_state;
  logic [KEY_WIDTH-1:0]     r_sync_reg;
  logic                     r_cap_done;
  logic                     r_sync_en;
  logic [CNT_W-1:0]         r_sample_cnt;

  logic                     w_load;
  logic                     w_accept;
  logic                     w_push;
  logic [SAMPLE_WIDTH-1:0]  w_push_data;
  logic                     w_push_sync;

  assign s_ready        = (r_state == ST_RUN) && enable && w_load;
  assign w_accept       = s_valid && s_ready;
  assign next_key_en    = w_accept;
  assign sync_en        = r_sync_en;
  assign sync_state_out = r_sync_reg;

  always_comb begin
    w_push      = 1'b0;
    w_push_data = '0;
    w_push_sync = 1'b0;
    case (r_state)
      ST_HDR0: begin
        w_push      = w_load;
        w_push_data = SAMPLE_WIDTH'(SYNC_WORD);
        w_push_sync = 1'b1;
      end
      ST_HDR1: begin
        w_push      = w_load;
        w_push_data = SAMPLE_WIDTH'(r_sync_reg[31:16]);
        w_push_sync = 1'b1;
      end
      ST_HDR2: begin
        w_push      = w_load;
        w_push_data = SAMPLE_WIDTH'(r_sync_reg[15:0]);
        w_push_sync = 1'b1;
      end
      ST_RUN: begin
        w_push      = w_accept;
        w_push_data = s_data ^ SAMPLE_WIDTH'(key_in[KEY_SLICE_HI:KEY_SLICE_LO]);
        w_push_sync = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sync_reg   <= '0;
      r_cap_done   <= 1'b0;
      r_sync_en    <= 1'b0;
      r_sample_cnt <= '0;
    end else begin
      r_sync_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (enable) r_state <= ST_HDR0;
        end
        ST_HDR0: begin
          // Capture once per header so a back-pressure stall cannot re-sample the key.
          if (!r_cap_done) begin
            r_sync_reg <= key_in;
            r_cap_done <= 1'b1;
          end
          if (w_load) begin
            r_cap_done <= 1'b0;
            r_state    <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (w_load) r_state <= ST_HDR2;
        end
        ST_HDR2: begin
          if (w_load) begin
            r_state   <= ST_SYNC;
            r_sync_en <= 1'b1;
          end
        end
        ST_SYNC: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_accept) begin
            if (r_sample_cnt == CNT_LAST) begin
              r_sample_cnt <= '0;
              r_state      <= ST_HDR0;
            end else begin
              r_sample_cnt <= r_sample_cnt + 1'b1;
            end
          end else if (!enable) begin
            r_sample_cnt <= '0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  stream_out_reg #(
    .W(SAMPLE_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_data    (w_push_data),
    .i_is_sync (w_push_sync),
    .i_m_ready (m_ready),
    .o_valid   (m_valid),
    .o_data    (m_data),
    .o_is_sync (m_is_sync),
    .o_load    (w_load)
  );

endmodule
